gnrl_dconv_accum_decim: RTL and testbench
=========================================

Name: gnrl_dconv_accum_decim

Overview:
- Sits directly downstream of the I/Q downconverter, which multiplies ADC samples by the 1,0,-1,0 sequence.
- Sums N consecutive enabled I and Q samples (boxcar integrate-and-dump) and emits one decimated complex result per N samples.
- Results leave through a one-deep valid/ready output register toward the capture FIFO / DMA.
- Start/stop control comes from the acquisition sequencer.

Parameters:
- IN_WIDTH, 15, width of signed two's-complement data_i/data_q from the downconverter
- ACC_WIDTH, 32, width of signed accumulators and outputs; must be ≥ IN_WIDTH
- DECIM_WIDTH, 16, width of the decimation-factor input and sample counter

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset
- data_i  input  IN_WIDTH  signed in-phase sample
- data_q  input  IN_WIDTH  signed quadrature sample
- conv_en  input  1  sample-valid strobe; same signal that advances the downconverter phase counter
- decim_factor  input  DECIM_WIDTH  N, samples per output; 0 is treated as 1
- start  input  1  one-cycle pulse that arms accumulation
- stop  input  1  one-cycle pulse that returns the block to idle
- out_i  output  ACC_WIDTH  signed summed I
- out_q  output  ACC_WIDTH  signed summed Q
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result when out_valid && out_ready
- busy  output  1  high while in ACCUM
- overflow  output  1  sticky flag: an unread result was overwritten

Behaviour:
- Reset (asynchronous, RESET high):
  - state = IDLE; acc_i, acc_q, count, out_i, out_q = 0
  - out_valid = 0, busy = 0, overflow = 0
  - Takes effect immediately mid-operation; any partial sum is discarded.
- States and transitions:
  - IDLE: accumulators held at 0; conv_en ignored.
    - On start: latch n_lat = (decim_factor==0 ? 1 : decim_factor), clear acc_i/acc_q/count, clear overflow, go to ACCUM.
  - ACCUM: busy = 1.
    - Each cycle with conv_en: acc += sign-extended sample, count += 1.
    - When conv_en and count == n_lat-1:
      - out_i/out_q <= acc + current sample (registered)
      - out_valid <= 1, acc <= 0, count <= 0
      - Stay in ACCUM (continuous decimation).
    - Cycles without conv_en: acc and count hold.
  - stop in ACCUM: go to IDLE and discard the partial sum; out_valid and a pending result are unaffected.
  - start in ACCUM: restart (relatch N, clear acc/count/overflow); the pending output is unaffected.
  - start and stop in the same cycle: stop wins.
- Priority: RESET > stop > start > accumulate.
- decim_factor is sampled only on start; later changes have no effect until the next start.
- Latency: the result is visible on out_i/out_q with out_valid=1 on the clock edge that captures the Nth enabled sample, i.e. one cycle after that sample is presented.
- Output handshake:
  - out_valid clears on the edge where out_valid && out_ready, unless a new result is produced on that same edge, in which case out_valid stays 1 with new data and overflow is not set.
  - If a new result is produced while out_valid=1 and out_ready=0: the new result overwrites out_i/out_q, out_valid stays 1, overflow <= 1.
  - overflow is sticky until start or RESET.
  - out_i/out_q are stable while out_valid=1 and not overwritten.
- Arithmetic:
  - Inputs are sign-extended to ACC_WIDTH.
  - Addition is modular two's complement in ACC_WIDTH: no saturation; wrap-around is the integrator's responsibility via ACC_WIDTH sizing.
  - ACC_WIDTH ≥ IN_WIDTH + DECIM_WIDTH guarantees no wrap.
- Counter: count is DECIM_WIDTH bits; the maximum N = 2^DECIM_WIDTH-1 is supported without wrap.

Test Plan:
1. start with N=4, out_ready=1, conv_en continuous, data_i=10,20,30,40, data_q=-1×4 -> one cycle after 4th sample out_i=100, out_q=-4, out_valid high 1 cycle; next 4 samples produce the next result.
2. N=3 with conv_en gaps (pattern 1,0,0,1,1), data_i=5 each -> out_i=15 only after 3rd enabled sample; counts/sums unchanged during gaps.
3. decim_factor=0, data_i=-7, data_q=3 each enabled cycle -> a result every enabled sample (out_i=-7, out_q=3); changing decim_factor mid-run to 8 has no effect until the next start.
4. N=2, out_ready=0 for 5 results -> out_valid stays 1, out_i reflects the latest sum, overflow=1 after the 2nd result; out_ready=1 one cycle -> out_valid=0, overflow stays 1 until start.
5. Assert RESET asynchronously (between edges) after 2 of 4 samples -> all outputs 0 immediately; after release and start, a fresh sum excludes the pre-reset samples. Also start+stop in the same cycle from ACCUM -> IDLE.
6. Drive from the upstream downconverter with constant adc AC value 100, N=4 -> out_i=0, out_q=0 every result (phase cancellation). Also N=2 aligned to phase 0 -> out_q alternates +100/-100, out_i alternates +100/-100.

Source files
------------

// File: rtl/gnrl_dconv_accum_decim.sv
// gnrl_dconv_accum_decim
//
// Boxcar integrate-and-dump decimator placed after the I/Q downconverter.
// Sums N consecutive enabled I and Q samples and emits one complex result
// per N samples through a one-deep valid/ready output register.
//
// Ports:
//   CLK          system clock
//   RESET        asynchronous, active-high reset
//   data_i       signed in-phase sample (IN_WIDTH)
//   data_q       signed quadrature sample (IN_WIDTH)
//   conv_en      sample-valid strobe shared with the downconverter phase counter
//   decim_factor samples per output N (0 behaves as 1), captured on start
//   start        one-cycle pulse: arm/restart accumulation
//   stop         one-cycle pulse: return to idle, dropping the partial sum
//   out_i/out_q  signed summed I/Q (ACC_WIDTH)
//   out_valid    result available
//   out_ready    consumer accepts when out_valid && out_ready
//   busy         high while accumulating
//   overflow     sticky: an unread result was overwritten
module gnrl_dconv_accum_decim #(
  parameter int IN_WIDTH    = 15,
  parameter int ACC_WIDTH   = 32,
  parameter int DECIM_WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic signed [IN_WIDTH-1:0]  data_i,
  input  logic signed [IN_WIDTH-1:0]  data_q,
  input  logic                        conv_en,
  input  logic [DECIM_WIDTH-1:0]      decim_factor,
  input  logic                        start,
  input  logic                        stop,
  output logic signed [ACC_WIDTH-1:0] out_i,
  output logic signed [ACC_WIDTH-1:0] out_q,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        overflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  logic [0:0]                  state;
  logic [DECIM_WIDTH-1:0]      n_lat;
  logic [DECIM_WIDTH-1:0]      count;
  logic signed [ACC_WIDTH-1:0] acc_i;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] ext_i;
  logic signed [ACC_WIDTH-1:0] ext_q;
  logic signed [ACC_WIDTH-1:0] sum_i;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic                        last_sample;

  // Sign-extend the incoming samples and form the running sums including the
  // current sample; the dump path uses these so the Nth sample lands in the
  // result on the same edge that captures it.
  always_comb begin
    ext_i       = ACC_WIDTH'(data_i);
    ext_q       = ACC_WIDTH'(data_q);
    sum_i       = acc_i + ext_i;
    sum_q       = acc_q + ext_q;
    last_sample = (count == n_lat - DECIM_WIDTH'(1));
  end

  assign busy = (state == ACCUM);

  // Control, accumulation and output register. Priority is stop > start >
  // accumulate; the consumer handshake is applied first so a dump on the same
  // edge simply re-asserts out_valid with the new data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      n_lat     <= DECIM_WIDTH'(1);
      count     <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (stop) begin
        state <= IDLE;
        acc_i <= '0;
        acc_q <= '0;
        count <= '0;
      end else if (start) begin
        state    <= ACCUM;
        n_lat    <= (decim_factor == '0) ? DECIM_WIDTH'(1) : decim_factor;
        acc_i    <= '0;
        acc_q    <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (state == ACCUM && conv_en) begin
        if (last_sample) begin
          out_i     <= sum_i;
          out_q     <= sum_q;
          out_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
          count     <= '0;
          // Only an unconsumed result being replaced counts as lost data.
          if (out_valid && !out_ready)
            overflow <= 1'b1;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          count <= count + DECIM_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gnrl_dconv_accum_decim.sv
// tb_gnrl_dconv_accum_decim
//
// Directed self-checking bench for gnrl_dconv_accum_decim. Inputs are driven
// right after a rising edge, outputs are sampled 1 time unit after it.
module tb_gnrl_dconv_accum_decim;

  localparam int IW = 15;
  localparam int AW = 32;
  localparam int DW = 16;

  logic                 CLK;
  logic                 RESET;
  logic signed [IW-1:0] data_i;
  logic signed [IW-1:0] data_q;
  logic                 conv_en;
  logic [DW-1:0]        decim_factor;
  logic                 start;
  logic                 stop;
  logic signed [AW-1:0] out_i;
  logic signed [AW-1:0] out_q;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 overflow;

  int checkCount = 0;
  int failCount  = 0;

  gnrl_dconv_accum_decim #(
    .IN_WIDTH(IW), .ACC_WIDTH(AW), .DECIM_WIDTH(DW)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .data_i(data_i), .data_q(data_q), .conv_en(conv_en),
    .decim_factor(decim_factor), .start(start), .stop(stop),
    .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one sample (or idle cycle) for a single clock.
  task automatic applyStimulus(input logic en, input int di, input int dq);
    conv_en = en;
    data_i  = IW'(di);
    data_q  = IW'(dq);
    tick();
    conv_en = 1'b0;
  endtask

  task automatic pulseStart(input int n);
    decim_factor = DW'(n);
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic signed [AW-1:0] observed,
                             input logic signed [AW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Downconverter model: I uses 1,0,-1,0 and Q uses 0,1,0,-1.
  int phase;
  task automatic dconvSample(input int adc);
    int mi, mq;
    case (phase)
      0: begin mi = 1;  mq = 0;  end
      1: begin mi = 0;  mq = 1;  end
      2: begin mi = -1; mq = 0;  end
      default: begin mi = 0; mq = -1; end
    endcase
    applyStimulus(1'b1, adc * mi, adc * mq);
    phase = (phase + 1) % 4;
  endtask

  initial begin
    RESET = 1'b1; conv_en = 1'b0; data_i = '0; data_q = '0;
    decim_factor = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checkOutput("rst_out_i", out_i, 0);
    checkOutput("rst_out_q", out_q, 0);
    checkOutput("rst_valid", AW'(out_valid), 0);
    checkOutput("rst_busy", AW'(busy), 0);
    checkOutput("rst_ovf", AW'(overflow), 0);
    RESET = 1'b0;
    tick();

    // Test 1: N=4 continuous
    pulseStart(4);
    checkOutput("t1_busy", AW'(busy), 1);
    applyStimulus(1'b1, 10, -1);
    applyStimulus(1'b1, 20, -1);
    applyStimulus(1'b1, 30, -1);
    checkOutput("t1_valid_early", AW'(out_valid), 0);
    applyStimulus(1'b1, 40, -1);
    checkOutput("t1_valid", AW'(out_valid), 1);
    checkOutput("t1_out_i", out_i, 100);
    checkOutput("t1_out_q", out_q, -4);
    applyStimulus(1'b1, 1, 2);
    checkOutput("t1_valid_drop", AW'(out_valid), 0);
    applyStimulus(1'b1, 2, 2);
    applyStimulus(1'b1, 3, 2);
    applyStimulus(1'b1, 4, 2);
    checkOutput("t1_out_i2", out_i, 10);
    checkOutput("t1_out_q2", out_q, 8);

    // Test 2: N=3 with enable gaps; gap data must be ignored
    pulseStart(3);
    applyStimulus(1'b1, 5, 0);
    applyStimulus(1'b0, 99, 99);
    applyStimulus(1'b0, 99, 99);
    applyStimulus(1'b1, 5, 0);
    checkOutput("t2_valid_early", AW'(out_valid), 0);
    applyStimulus(1'b1, 5, 0);
    checkOutput("t2_valid", AW'(out_valid), 1);
    checkOutput("t2_out_i", out_i, 15);

    // Test 3: N=0 behaves as 1; decim_factor change ignored until start
    pulseStart(0);
    applyStimulus(1'b1, -7, 3);
    checkOutput("t3_out_i", out_i, -7);
    checkOutput("t3_out_q", out_q, 3);
    checkOutput("t3_valid", AW'(out_valid), 1);
    decim_factor = DW'(8);
    applyStimulus(1'b1, -2, 1);
    checkOutput("t3_late_i", out_i, -2);
    checkOutput("t3_late_valid", AW'(out_valid), 1);

    // Test 4: N=2, consumer stalled for 5 results
    pulseStart(2);
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, k, 0);
      if (k == 2) checkOutput("t4_ovf_r1", AW'(overflow), 0);
      if (k == 4) checkOutput("t4_ovf_r2", AW'(overflow), 1);
    end
    checkOutput("t4_valid", AW'(out_valid), 1);
    checkOutput("t4_out_i", out_i, 19);
    out_ready = 1'b1;
    applyStimulus(1'b0, 0, 0);
    checkOutput("t4_valid_clr", AW'(out_valid), 0);
    checkOutput("t4_ovf_sticky", AW'(overflow), 1);
    pulseStart(4);
    checkOutput("t4_ovf_clr", AW'(overflow), 0);

    // Test 5: asynchronous reset mid-accumulation
    applyStimulus(1'b1, 100, 100);
    applyStimulus(1'b1, 100, 100);
    #2 RESET = 1'b1;
    #1;
    checkOutput("t5_rst_out_i", out_i, 0);
    checkOutput("t5_rst_busy", AW'(busy), 0);
    #1 RESET = 1'b0;
    tick();
    pulseStart(4);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1, -1);
    checkOutput("t5_fresh_i", out_i, 4);
    checkOutput("t5_fresh_q", out_q, -4);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checkOutput("t5_startstop_busy", AW'(busy), 0);

    // Test 6: driven through a downconverter model, constant ADC value 100
    pulseStart(4);
    phase = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) dconvSample(100);
      checkOutput("t6_n4_i", out_i, 0);
      checkOutput("t6_n4_q", out_q, 0);
      checkOutput("t6_n4_valid", AW'(out_valid), 1);
    end
    pulseStart(2);
    phase = 0;
    for (int r = 0; r < 4; r++) begin
      dconvSample(100);
      dconvSample(100);
      checkOutput("t6_n2_i", out_i, (r % 2 == 0) ? 100 : -100);
      checkOutput("t6_n2_q", out_q, (r % 2 == 0) ? 100 : -100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
